lock_monitor: RTL and testbench

Lock-state detector that drives `out_of_lock` into the ramp/relock scanner. It checks a monitored signal, such as transmission or an error-signal envelope, against a programmable window. Entry into and exit from lock are both debounced by cycle counts. It also keeps a saturating count of lock-loss events and a sticky flag for the register bank.

---
 rtl/lock_monitor.sv | 140 ++++++++++++++
 tb/tb_lock_monitor.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_monitor.sv
// Lock-state detector: registered window compare feeding a debounced lock FSM,
// plus a saturating lock-loss counter and sticky flag for the register bank.
module lock_monitor #(
  parameter int R = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic signed [R-1:0] signal_in,
  input  logic signed [R-1:0] lock_min,
  input  logic signed [R-1:0] lock_max,
  input  logic [31:0]         hold_time,
  input  logic [31:0]         relock_time,
  input  logic                clear,
  output logic                out_of_lock,
  output logic                lock_lost,
  output logic                in_window,
  output logic [2:0]          state,
  output logic [15:0]         unlock_count,
  output logic                unlock_latched
);

  typedef enum logic [2:0] {
    ST_DISABLED = 3'd0,
    ST_LOCKED   = 3'd1,
    ST_SUSPECT  = 3'd2,
    ST_UNLOCKED = 3'd3,
    ST_RECOVER  = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] cnt_r, cnt_s;
  logic        in_window_r;
  logic        lock_lost_r, lock_lost_s;
  logic [15:0] unlock_count_r;
  logic        unlock_latched_r;
  logic [32:0] cnt_inc_s, hold_lim_s, relock_lim_s;

  // One extra bit keeps cnt+1 from wrapping when a limit is 32'hFFFFFFFF.
  assign cnt_inc_s    = {1'b0, cnt_r} + 33'd1;
  assign hold_lim_s   = (hold_time == 32'd0)   ? 33'd1 : {1'b0, hold_time};
  assign relock_lim_s = (relock_time == 32'd0) ? 33'd1 : {1'b0, relock_time};

  // Window compare stage: inclusive signed limits; an inverted window never matches.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_window_r <= 1'b0;
    end else begin
      in_window_r <= (signal_in >= lock_min) && (signal_in <= lock_max);
    end
  end

  // Next-state logic for the debounce FSM.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    lock_lost_s = 1'b0;
    if (!enable) begin
      state_s = ST_DISABLED;
      cnt_s   = 32'd0;
    end else begin
      case (state_r)
        ST_DISABLED: begin
          state_s = ST_LOCKED;
          cnt_s   = 32'd0;
        end
        ST_LOCKED, ST_SUSPECT: begin
          if (in_window_r) begin
            state_s = ST_LOCKED;
            cnt_s   = 32'd0;
          end else if (cnt_inc_s >= hold_lim_s) begin
            state_s     = ST_UNLOCKED;
            cnt_s       = 32'd0;
            lock_lost_s = 1'b1;
          end else begin
            state_s = ST_SUSPECT;
            cnt_s   = cnt_inc_s[31:0];
          end
        end
        ST_UNLOCKED, ST_RECOVER: begin
          if (!in_window_r) begin
            state_s = ST_UNLOCKED;
            cnt_s   = 32'd0;
          end else if (cnt_inc_s >= relock_lim_s) begin
            state_s = ST_LOCKED;
            cnt_s   = 32'd0;
          end else begin
            state_s = ST_RECOVER;
            cnt_s   = cnt_inc_s[31:0];
          end
        end
        default: begin
          state_s = ST_DISABLED;
          cnt_s   = 32'd0;
        end
      endcase
    end
  end

  // FSM state, counter and lock-loss pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_DISABLED;
      cnt_r       <= 32'd0;
      lock_lost_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      lock_lost_r <= lock_lost_s;
    end
  end

  // Event statistics: a lock-loss on the same edge as clear takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      unlock_count_r   <= 16'd0;
      unlock_latched_r <= 1'b0;
    end else if (lock_lost_s) begin
      if (clear) begin
        unlock_count_r <= 16'd1;
      end else if (unlock_count_r == 16'hFFFF) begin
        unlock_count_r <= 16'hFFFF;
      end else begin
        unlock_count_r <= unlock_count_r + 16'd1;
      end
      unlock_latched_r <= 1'b1;
    end else if (clear) begin
      unlock_count_r   <= 16'd0;
      unlock_latched_r <= 1'b0;
    end
  end

  assign out_of_lock    = (state_r == ST_UNLOCKED) || (state_r == ST_RECOVER);
  assign lock_lost      = lock_lost_r;
  assign in_window      = in_window_r;
  assign state          = state_r;
  assign unlock_count   = unlock_count_r;
  assign unlock_latched = unlock_latched_r;

endmodule

// File: tb/tb_lock_monitor.sv
// Directed self-checking bench for lock_monitor; outputs are sampled 1 time unit
// after each rising edge, inputs are changed at that same point.
module tb_lock_monitor;

  logic               clk;
  logic               rst;
  logic               enable;
  logic signed [13:0] signal_in;
  logic signed [13:0] lock_min;
  logic signed [13:0] lock_max;
  logic [31:0]        hold_time;
  logic [31:0]        relock_time;
  logic               clear;
  logic               out_of_lock;
  logic               lock_lost;
  logic               in_window;
  logic [2:0]         state;
  logic [15:0]        unlock_count;
  logic               unlock_latched;

  int total = 0;
  int bad   = 0;

  lock_monitor #(.R(14)) dut (
    .clk(clk), .rst(rst), .enable(enable), .signal_in(signal_in),
    .lock_min(lock_min), .lock_max(lock_max), .hold_time(hold_time),
    .relock_time(relock_time), .clear(clear), .out_of_lock(out_of_lock),
    .lock_lost(lock_lost), .in_window(in_window), .state(state),
    .unlock_count(unlock_count), .unlock_latched(unlock_latched)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; signal_in = 14'sd0; clear = 1'b0;
    lock_min = -14'sd100; lock_max = 14'sd100;
    hold_time = 32'd4; relock_time = 32'd8;
    tick(); tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ool", 32'(out_of_lock), 32'd0);
    chk("rst_lost", 32'(lock_lost), 32'd0);
    chk("rst_inwin", 32'(in_window), 32'd0);
    chk("rst_count", 32'(unlock_count), 32'd0);
    chk("rst_latch", 32'(unlock_latched), 32'd0);
    rst = 1'b0;
    tick();
    chk("disabled_hold", 32'(state), 32'd0);
    enable = 1'b1;
    tick();
    chk("enable_locked", 32'(state), 32'd1);
    chk("enable_inwin", 32'(in_window), 32'd1);
    tick();

    // Basic lock loss: H=4
    signal_in = 14'sd500;
    tick();
    chk("t0_inwin", 32'(in_window), 32'd0);
    chk("t0_state", 32'(state), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("suspect_state", 32'(state), 32'd2);
      chk("suspect_ool", 32'(out_of_lock), 32'd0);
    end
    tick();
    chk("unlock_state", 32'(state), 32'd3);
    chk("unlock_ool", 32'(out_of_lock), 32'd1);
    chk("unlock_pulse", 32'(lock_lost), 32'd1);
    chk("unlock_count1", 32'(unlock_count), 32'd1);
    chk("unlock_latch1", 32'(unlock_latched), 32'd1);
    tick();
    chk("pulse_end", 32'(lock_lost), 32'd0);
    chk("unlock_stay", 32'(state), 32'd3);

    // 7-cycle in-window burst with L=8 must not relock
    signal_in = 14'sd0;
    for (int i = 0; i < 7; i++) tick();
    signal_in = 14'sd500;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("relock_glitch_ool", 32'(out_of_lock), 32'd1);
    end
    chk("relock_glitch_state", 32'(state), 32'd3);

    // Relock: 3 -> 4 x7 -> 1
    signal_in = 14'sd0;
    tick();
    chk("t1_state", 32'(state), 32'd3);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("recover_state", 32'(state), 32'd4);
      chk("recover_ool", 32'(out_of_lock), 32'd1);
    end
    tick();
    chk("relock_state", 32'(state), 32'd1);
    chk("relock_ool", 32'(out_of_lock), 32'd0);

    // 3-cycle out-of-window glitch with H=4 must not unlock
    signal_in = 14'sd500;
    tick(); tick(); tick();
    signal_in = 14'sd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("glitch_ool", 32'(out_of_lock), 32'd0);
    end
    chk("glitch_state", 32'(state), 32'd1);
    chk("glitch_count", 32'(unlock_count), 32'd1);

    // Zero hold/relock times behave as 1
    hold_time = 32'd0; relock_time = 32'd0;
    signal_in = 14'sd500;
    tick();
    chk("h0_t0", 32'(state), 32'd1);
    tick();
    chk("h0_unlock", 32'(state), 32'd3);
    chk("h0_count", 32'(unlock_count), 32'd2);
    signal_in = 14'sd0;
    tick();
    chk("l0_t1", 32'(state), 32'd3);
    tick();
    chk("l0_relock", 32'(state), 32'd1);
    chk("l0_ool", 32'(out_of_lock), 32'd0);

    // Empty window: 0 is between the limits but min > max
    hold_time = 32'd4;
    lock_min = 14'sd50; lock_max = -14'sd50;
    tick();
    chk("empty_inwin", 32'(in_window), 32'd0);
    chk("empty_t0", 32'(state), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("empty_suspect", 32'(state), 32'd2);
    end
    tick();
    chk("empty_unlock", 32'(state), 32'd3);
    chk("empty_inwin2", 32'(in_window), 32'd0);
    chk("empty_count", 32'(unlock_count), 32'd3);

    // Inclusive window boundaries
    lock_min = -14'sd100; lock_max = 14'sd100;
    signal_in = 14'sd100;
    tick();
    chk("edge_max", 32'(in_window), 32'd1);
    signal_in = -14'sd100;
    tick();
    chk("edge_min", 32'(in_window), 32'd1);
    chk("edge_relock", 32'(state), 32'd1);
    signal_in = 14'sd101;
    tick();
    chk("edge_max_out", 32'(in_window), 32'd0);
    signal_in = -14'sd101;
    tick();
    chk("edge_min_out", 32'(in_window), 32'd0);
    chk("edge_suspect", 32'(state), 32'd2);
    signal_in = 14'sd0;
    tick(); tick();
    chk("edge_back", 32'(state), 32'd1);

    // Saturation: preload the counter just below the ceiling
    hold_time = 32'd0;
    force dut.unlock_count_r = 16'hFFFE;
    #1;
    release dut.unlock_count_r;
    signal_in = 14'sd500;
    tick(); tick();
    chk("sat_ffff", 32'(unlock_count), 32'h0000FFFF);
    signal_in = 14'sd0;
    tick(); tick();
    chk("sat_relock", 32'(state), 32'd1);
    signal_in = 14'sd500;
    tick(); tick();
    chk("sat_hold", 32'(unlock_count), 32'h0000FFFF);
    chk("sat_pulse", 32'(lock_lost), 32'd1);

    // Clear on the same edge as a lock loss: event wins
    signal_in = 14'sd0;
    tick(); tick();
    signal_in = 14'sd500;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_evt_state", 32'(state), 32'd3);
    chk("clr_evt_count", 32'(unlock_count), 32'd1);
    chk("clr_evt_latch", 32'(unlock_latched), 32'd1);

    // Drop enable while in RECOVER
    relock_time = 32'd8;
    signal_in = 14'sd0;
    tick(); tick(); tick();
    chk("pre_dis_state", 32'(state), 32'd4);
    enable = 1'b0;
    tick();
    chk("dis_state", 32'(state), 32'd0);
    chk("dis_ool", 32'(out_of_lock), 32'd0);
    chk("dis_count", 32'(unlock_count), 32'd1);
    chk("dis_latch", 32'(unlock_latched), 32'd1);
    enable = 1'b1;
    tick();
    chk("reen_state", 32'(state), 32'd1);

    // Clear alone
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_count", 32'(unlock_count), 32'd0);
    chk("clr_latch", 32'(unlock_latched), 32'd0);

    // Reset while UNLOCKED
    signal_in = 14'sd500;
    tick(); tick();
    chk("pre_rst_state", 32'(state), 32'd3);
    rst = 1'b1;
    tick();
    chk("mrst_state", 32'(state), 32'd0);
    chk("mrst_ool", 32'(out_of_lock), 32'd0);
    chk("mrst_lost", 32'(lock_lost), 32'd0);
    chk("mrst_inwin", 32'(in_window), 32'd0);
    chk("mrst_count", 32'(unlock_count), 32'd0);
    chk("mrst_latch", 32'(unlock_latched), 32'd0);
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
